// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter: datapath width, the ALU
// function codes seen on the shared port, and the arbiter FSM encoding.
package alu_pkg;

    localparam int XLEN = 64;

    // funct3 codes carried through to the ALU (no decode happens here)
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;

    // funct7 modifier selecting SUB (ignored by the ALU for immediate ADD)
    localparam logic [6:0] FUNCT7_SUB = 7'b0100000;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Index of the owner encoded in a one-hot two-bit grant
    function automatic logic onehot2_idx(input logic [1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_arb2.sv
// rr_arb2: two-input winner picker for the ALU arbiter.
// Round-robin by default: on a tie the requester that did not win last
// time is chosen. Build option ALU_ARB_FIXED_PRIO_EN switches ties to a
// fixed priority for requester 0; last_grant is then not consulted.
module rr_arb2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] win
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    // requester 0 always wins a tie
    always_comb begin
        win    = 2'b00;
        win[0] = valid0;
        win[1] = valid1 & ~valid0;
    end
`else
    // tie goes to whichever requester was not granted last
    always_comb begin
        win = 2'b00;
        if (valid0 && valid1) begin
            win = last_grant ? 2'b01 : 2'b10;
        end else begin
            win[0] = valid0;
            win[1] = valid1;
        end
    end
`endif

endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one registered-output ALU between the execute
// stage (req0) and the address/branch-compare helper (req1). One operation
// is in flight at a time: accept, hold operands for ALU_LAT+1 edges,
// capture the result and return it on the owner's response channel.
// Build option ALU_ARB_FIXED_PRIO_EN (see rr_arb2) gives req0 fixed
// priority on ties; everything else is identical in both builds.
//
// state | meaning
// IDLE  | no operation owned; winner sees ready and is latched on the edge
// EXEC  | operands held on the ALU port, counting down the ALU latency
// RESP  | result held on the owner's rsp channel until it is consumed
module alu_req_arbiter #(
    parameter int XLEN    = alu_pkg::XLEN,
    parameter int ALU_LAT = 1
) (
    input  logic            CLK,
    input  logic            RST,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_op1,
    input  logic [XLEN-1:0] req0_op2,
    input  logic [2:0]      req0_funct3,
    input  logic [6:0]      req0_funct7,
    input  logic            req0_imm,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_op1,
    input  logic [XLEN-1:0] req1_op2,
    input  logic [2:0]      req1_funct3,
    input  logic [6:0]      req1_funct7,
    input  logic            req1_imm,

    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_res,

    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_res,

    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    output logic [2:0]      alu_funct3,
    output logic [6:0]      alu_funct7,
    output logic            alu_imm,
    input  logic [XLEN-1:0] alu_res,

    output logic [1:0]      gnt,
    output logic            busy
);

    import alu_pkg::*;

    // Counter only needs to hold ALU_LAT; keep at least one bit
    localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             last_grant;
    logic [1:0]       win;
    logic [1:0]       gnt_q;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             capture;
    logic             done;
    logic [1:0]       rsp_valid_vec;
    logic [1:0]       rsp_ready_vec;

    rr_arb2 u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .win        (win)
    );

    assign rsp_ready_vec = {rsp1_ready, rsp0_ready};

    // Next-state and handshake decode; ready is withheld while reset is held
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        capture       = 1'b0;
        done          = 1'b0;
        rsp_valid_vec = 2'b00;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;

        unique case (state)
            IDLE: begin
                if (!RST) begin
                    req0_ready = win[0];
                    req1_ready = win[1];
                    if (|win) begin
                        accept    = 1'b1;
                        state_nxt = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid_vec = gnt_q;
                if (|(rsp_valid_vec & rsp_ready_vec)) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rsp0_valid = rsp_valid_vec[0];
    assign rsp1_valid = rsp_valid_vec[1];
    assign gnt        = gnt_q;
    assign busy       = (state != IDLE);

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ownership of the in-flight op and round-robin history (req0 wins first)
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gnt_q      <= 2'b00;
            last_grant <= 1'b1;
        end else if (accept) begin
            gnt_q      <= win;
            last_grant <= onehot2_idx(win);
        end else if (done) begin
            gnt_q      <= 2'b00;
        end
    end

    // Latch the winner's operands and hold them on the ALU port
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_funct3 <= '0;
            alu_funct7 <= '0;
            alu_imm    <= 1'b0;
        end else if (accept) begin
            if (win[0]) begin
                alu_op1    <= req0_op1;
                alu_op2    <= req0_op2;
                alu_funct3 <= req0_funct3;
                alu_funct7 <= req0_funct7;
                alu_imm    <= req0_imm;
            end else begin
                alu_op1    <= req1_op1;
                alu_op2    <= req1_op2;
                alu_funct3 <= req1_funct3;
                alu_funct7 <= req1_funct7;
                alu_imm    <= req1_imm;
            end
        end
    end

    // ALU latency down-counter; result is taken on the edge it reads zero
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_LOAD;
        end else if (state == EXEC && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Result capture into the owner's response register; the other keeps its value
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp0_res <= '0;
            rsp1_res <= '0;
        end else if (capture) begin
            if (gnt_q[0]) begin
                rsp0_res <= alu_res;
            end
            if (gnt_q[1]) begin
                rsp1_res <= alu_res;
            end
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a registered ALU model, two requester agents
// fed from queues, a transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then a random phase.
module tb_alu_req_arbiter;
    import alu_pkg::*;

    localparam int W   = 64;
    localparam int LAT = 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   f3;
        logic [6:0]   f7;
        logic         imm;
    } op_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    logic         v   [2];
    logic [W-1:0] o1  [2];
    logic [W-1:0] o2  [2];
    logic [2:0]   f3  [2];
    logic [6:0]   f7  [2];
    logic         im  [2];
    logic         rr  [2];

    logic         rdy0, rdy1, rv0, rv1, aimm, busy;
    logic [W-1:0] res0, res1, a1, a2;
    logic [W-1:0] alu_res = '0;
    logic [2:0]   af3;
    logic [6:0]   af7;
    logic [1:0]   gnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    op_t q0[$];
    op_t q1[$];
    logic [W-1:0] r0[$];
    logic [W-1:0] r1[$];
    int gnt_log[$];
    int acc_cyc[2];
    int hs_cyc[2];
    int rv_cnt[2];
    logic rv_prev[2];

    alu_req_arbiter #(.XLEN(W), .ALU_LAT(LAT)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(v[0]), .req0_ready(rdy0), .req0_op1(o1[0]), .req0_op2(o2[0]),
        .req0_funct3(f3[0]), .req0_funct7(f7[0]), .req0_imm(im[0]),
        .req1_valid(v[1]), .req1_ready(rdy1), .req1_op1(o1[1]), .req1_op2(o2[1]),
        .req1_funct3(f3[1]), .req1_funct7(f7[1]), .req1_imm(im[1]),
        .rsp0_valid(rv0), .rsp0_ready(rr[0]), .rsp0_res(res0),
        .rsp1_valid(rv1), .rsp1_ready(rr[1]), .rsp1_res(res1),
        .alu_op1(a1), .alu_op2(a2), .alu_funct3(af3), .alu_funct7(af7), .alu_imm(aimm),
        .alu_res(alu_res), .gnt(gnt), .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] fn3, input logic [6:0] fn7,
                                           input logic imm);
        case (fn3)
            F3_ADD_SUB: return (!imm && fn7 == FUNCT7_SUB) ? a - b : a + b;
            F3_SLL:     return a << b[5:0];
            F3_SLT:     return W'($signed(a) < $signed(b));
            F3_SLTU:    return W'(a < b);
            3'b100:     return a ^ b;
            3'b101:     return (fn7 == FUNCT7_SUB) ? W'($signed(a) >>> b[5:0]) : a >> b[5:0];
            3'b110:     return a | b;
            default:    return a & b;
        endcase
    endfunction

    // registered ALU, one edge of latency
    always @(posedge CLK) alu_res <= alu_f(a1, a2, af3, af7, aimm);

    function automatic op_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] fn3, input logic [6:0] fn7, input logic imm);
        op_t o;
        o.a = a; o.b = b; o.f3 = fn3; o.f7 = fn7; o.imm = imm;
        return o;
    endfunction

    // who wins from the rules: sole valid, else the one not granted last
    function automatic int pick(input logic va, input logic vb, input int last);
        if (va && vb) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            return 0;
`else
            return (last == 0) ? 1 : 0;
`endif
        end
        if (va) return 0;
        if (vb) return 1;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: owner (-1 idle), edges since accept, result per requester
    int           m_owner = -1;
    int           m_age = 0;
    int           m_last = 1;
    op_t          m_op;
    logic [W-1:0] m_exp = '0;
    logic [W-1:0] m_res [2];

    always @(posedge CLK or posedge RST) begin
        int w;
        if (RST) begin
            m_owner = -1; m_age = 0; m_last = 1;
            m_op = mk('0, '0, 3'd0, 7'd0, 1'b0);
            m_res[0] = '0; m_res[1] = '0;
        end else if (m_owner < 0) begin
            w = pick(v[0], v[1], m_last);
            if (w >= 0) begin
                m_owner = w; m_age = 0; m_last = w;
                m_op  = mk(o1[w], o2[w], f3[w], f7[w], im[w]);
                m_exp = alu_f(m_op.a, m_op.b, m_op.f3, m_op.f7, m_op.imm);
            end
        end else if (m_age >= LAT + 1) begin
            if (rr[m_owner]) m_owner = -1;
        end else begin
            m_age++;
            if (m_age == LAT + 1) m_res[m_owner] = m_exp;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge CLK) begin
        logic [1:0] e_rdy, e_rv, e_gnt;
        int w;
        w = pick(v[0], v[1], m_last);
        e_rdy = 2'b00;
        if (!RST && m_owner < 0 && w >= 0) e_rdy[w] = 1'b1;
        e_rv = 2'b00;
        if (m_owner >= 0 && m_age >= LAT + 1) e_rv[m_owner] = 1'b1;
        e_gnt = 2'b00;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        chk("req_ready", W'({rdy1, rdy0}), W'(e_rdy));
        chk("rsp_valid", W'({rv1, rv0}), W'(e_rv));
        chk("gnt", W'(gnt), W'(e_gnt));
        chk("busy", W'(busy), W'(m_owner >= 0));
        chk("alu_op1", a1, m_op.a);
        chk("alu_op2", a2, m_op.b);
        chk("alu_ctl", W'({af3, af7, aimm}), W'({m_op.f3, m_op.f7, m_op.imm}));
        chk("rsp0_res", res0, m_res[0]);
        chk("rsp1_res", res1, m_res[1]);
    end

    // Transaction monitor: grant order, handshakes, latency
    always @(negedge CLK) begin
        if (!RST) begin
            if (v[0] && rdy0) begin gnt_log.push_back(0); acc_cyc[0] = cyc; end
            if (v[1] && rdy1) begin gnt_log.push_back(1); acc_cyc[1] = cyc; end
            // ready cycle plus ALU_LAT+1 edges to the first valid cycle
            if (rv0 && !rv_prev[0]) chk("rsp0_latency", W'(cyc - acc_cyc[0]), W'(LAT + 2));
            if (rv1 && !rv_prev[1]) chk("rsp1_latency", W'(cyc - acc_cyc[1]), W'(LAT + 2));
            if (rv0) rv_cnt[0]++;
            if (rv1) rv_cnt[1]++;
            if (rv0 && rr[0]) begin r0.push_back(res0); hs_cyc[0] = cyc; end
            if (rv1 && rr[1]) begin r1.push_back(res1); hs_cyc[1] = cyc; end
        end
        rv_prev[0] = rv0;
        rv_prev[1] = rv1;
    end

    // Requester agent: presents queued ops, holds each until accepted
    task automatic agent(input int n);
        op_t  op;
        logic acc, got;
        v[n] = 1'b0; o1[n] = '0; o2[n] = '0; f3[n] = '0; f7[n] = '0; im[n] = 1'b0;
        forever begin
            @(negedge CLK);
            acc = v[n] && ((n == 0) ? rdy0 : rdy1) && !RST;
            @(posedge CLK);
            #1;
            if (acc) v[n] = 1'b0;
            if (!v[n]) begin
                got = 1'b0;
                if (n == 0 && q0.size() > 0) begin op = q0.pop_front(); got = 1'b1; end
                if (n == 1 && q1.size() > 0) begin op = q1.pop_front(); got = 1'b1; end
                if (got) begin
                    o1[n] = op.a; o2[n] = op.b; f3[n] = op.f3; f7[n] = op.f7; im[n] = op.imm;
                    v[n] = 1'b1;
                end
            end
        end
    endtask

    initial agent(0);
    initial agent(1);

    task automatic wait_resp(input int n0, input int n1, input int budget, input string name);
        int k = 0;
        while ((r0.size() < n0 || r1.size() < n1) && k < budget) begin
            @(posedge CLK);
            k++;
        end
        chk(name, W'(r0.size() >= n0 && r1.size() >= n1), W'(1));
    endtask

    task automatic clear_logs();
        r0.delete(); r1.delete(); gnt_log.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout reached without finishing");
        $fatal(1);
    end

    initial begin
        int k;
        int snap;
        int exp_seq[8];
        rr[0] = 1'b1; rr[1] = 1'b1;
        rv_cnt[0] = 0; rv_cnt[1] = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0; hs_cyc[0] = 0; hs_cyc[1] = 0;
        #1 RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_gnt", W'(gnt), W'(0));
        chk("reset_busy", W'(busy), W'(0));
        @(posedge CLK); #1 RST = 1'b0;

        // single SUB on req0
        @(negedge CLK);
        clear_logs();
        snap = rv_cnt[1];
        q0.push_back(mk(64'd5, 64'd3, F3_ADD_SUB, FUNCT7_SUB, 1'b0));
        wait_resp(1, 0, 30, "sub_done");
        chk("sub_res", r0[0], 64'd2);
        chk("sub_ready_cycles", W'(gnt_log.size()), W'(1));
        chk("sub_no_rsp1", W'(rv_cnt[1] - snap), W'(0));

        // reset mid-EXEC drops the op
        @(negedge CLK);
        q0.push_back(mk(64'd100, 64'd1, F3_ADD_SUB, 7'd0, 1'b0));
        k = 0;
        while (!busy && k < 20) begin @(negedge CLK); k++; end
        chk("rst_test_busy_seen", W'(busy), W'(1));
        @(posedge CLK); #1 RST = 1'b1;
        #1;
        chk("rst_gnt", W'(gnt), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_rsp0_valid", W'(rv0), W'(0));
        chk("rst_alu_op1", a1, W'(0));
        @(posedge CLK); #1 RST = 1'b0;
        snap = rv_cnt[0];
        repeat (10) @(posedge CLK);
        chk("rst_dropped", W'(rv_cnt[0] - snap), W'(0));

        // simultaneous requests after reset: req0 first
        @(negedge CLK);
        clear_logs();
        q0.push_back(mk(64'd1, 64'd2, F3_ADD_SUB, 7'd0, 1'b0));
        q1.push_back(mk(64'd1, '1, F3_SLTU, 7'd0, 1'b0));
        wait_resp(1, 1, 60, "simul_done");
        chk("simul_res0", r0[0], 64'd3);
        chk("simul_res1", r1[0], 64'd1);
        chk("simul_gnt_count", W'(gnt_log.size()), W'(2));
        chk("simul_first", W'(gnt_log[0]), W'(0));
        chk("simul_second", W'(gnt_log[1]), W'(1));

        // backpressure on rsp0 while req1 waits
        @(posedge CLK); #1 rr[0] = 1'b0;
        @(negedge CLK);
        clear_logs();
        q0.push_back(mk(64'd7, 64'd8, F3_ADD_SUB, 7'd0, 1'b0));
        k = 0;
        while (!rv0 && k < 30) begin @(negedge CLK); k++; end
        q1.push_back(mk(64'd4, 64'd4, F3_ADD_SUB, 7'd0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp_rsp0_valid", W'(rv0), W'(1));
            chk("bp_rsp0_res", res0, 64'd15);
            chk("bp_req1_ready", W'(rdy1), W'(0));
        end
        @(posedge CLK); #1 rr[0] = 1'b1;
        wait_resp(1, 1, 40, "bp_done");
        chk("bp_res1", r1[0], 64'd8);
        chk("bp_req1_next_idle", W'(acc_cyc[1] - hs_cyc[0]), W'(1));

        // function passthrough on req1
        @(negedge CLK);
        clear_logs();
        q1.push_back(mk('1, 64'd1, F3_SLT, 7'd0, 1'b0));
        q1.push_back(mk(64'd10, 64'd3, F3_ADD_SUB, FUNCT7_SUB, 1'b1));
        q1.push_back(mk(64'd1, 64'd63, F3_SLL, 7'd0, 1'b0));
        wait_resp(0, 3, 60, "pass_done");
        chk("pass_slt", r1[0], 64'd1);
        chk("pass_imm_add", r1[1], 64'd13);
        chk("pass_sll", r1[2], 64'h8000_0000_0000_0000);

        // fairness: 4 back-to-back ops from each side
        @(negedge CLK);
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(W'(i), 64'd1, F3_ADD_SUB, 7'd0, 1'b0));
            q1.push_back(mk(W'(i), 64'd2, F3_ADD_SUB, 7'd0, 1'b0));
        end
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        wait_resp(4, 4, 200, "fair_done");
        chk("fair_count", W'(gnt_log.size()), W'(8));
        for (int i = 0; i < 8; i++) chk($sformatf("fair_order_%0d", i), W'(gnt_log[i]), W'(exp_seq[i]));

        // random traffic and backpressure
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK); #1;
            rr[0] = ($urandom_range(0, 3) != 0);
            rr[1] = ($urandom_range(0, 3) != 0);
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(0, 3) == 0) begin
                    op_t o;
                    o = mk({$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                           ($urandom_range(0, 1) != 0) ? FUNCT7_SUB : 7'd0, 1'($urandom_range(0, 1)));
                    if (n == 0 && q0.size() < 3) q0.push_back(o);
                    if (n == 1 && q1.size() < 3) q1.push_back(o);
                end
            end
        end
        @(posedge CLK); #1 rr[0] = 1'b1; rr[1] = 1'b1;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || v[0] || v[1] || busy) && k < 500) begin
            @(posedge CLK);
            k++;
        end
        chk("drain_idle", W'(k < 500), W'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares the single registered-output integer ALU between two requesters: req0 is the execute stage and req1 is the address/branch-compare helper.
- Arbitrates round-robin and holds the granted operands stable on the ALU inputs.
- Waits the ALU's registered latency, captures the result, and returns it over a valid/ready response channel.
- Only one operation is in flight at a time.

Parameters:
- XLEN, 64, operand/result width.
- ALU_LAT, 1, clock edges from operands stable at the ALU inputs to alu_res valid (minimum 1).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  asynchronous active-high reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_op1, req0_op2 / req1_op1, req1_op2  in  XLEN  operands.
- req0_funct3 / req1_funct3  in  3  ALU function.
- req0_funct7 / req1_funct7  in  7  ALU function modifier.
- req0_imm / req1_imm  in  1  immediate-form op (funct7 ignored for ADD).
- rsp0_valid / rsp1_valid  out  1  result available.
- rsp0_ready / rsp1_ready  in  1  result consumed.
- rsp0_res / rsp1_res  out  XLEN  result.
- alu_op1, alu_op2  out  XLEN  to ALU.
- alu_funct3  out  3  to ALU.
- alu_funct7  out  7  to ALU.
- alu_imm  out  1  to ALU.
- alu_res  in  XLEN  from ALU, registered inside the ALU.
- gnt  out  2  one-hot owner of the current operation; 0 when idle.
- busy  out  1  high in EXEC and RESP.

Behaviour:
- Reset (async, RST=1), immediately:
  - state=IDLE, gnt=0, busy=0.
  - all req*_ready=0, rsp*_valid=0, rsp*_res=0.
  - alu_* outputs = 0.
  - last_grant=1, so req0 wins first.
  - An in-flight operation is dropped and no response is ever produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner: the only valid requester; if both are valid, the requester that is not last_grant.
  - reqN_ready=1 combinationally for the winner only. Ready may depend on valid.
  - Requesters must hold valid and payload stable until ready.
  - On the accept edge: latch winner's op1/op2/funct3/funct7/imm into the alu_* registers, set gnt, last_grant=winner, cnt=ALU_LAT, go to EXEC.
- EXEC:
  - alu_* held constant; cnt decrements each edge.
  - On the edge where cnt==0: capture alu_res into rspN_res of the granted requester, go to RESP.
  - Accept-edge to rsp_valid = ALU_LAT+1 cycles (2 for default).
- RESP:
  - rspN_valid=1 for the granted requester only; rspN_res stable.
  - Held indefinitely while rspN_ready=0.
  - On valid&&ready edge: rspN_valid=0, gnt=0, go to IDLE.
  - No new request is accepted in the same cycle. Minimum 4 cycles per operation at ALU_LAT=1.
- req*_ready is 0 in EXEC and RESP regardless of valid.
- rsp_res of the non-granted requester keeps its last value; it is meaningful only while its valid=1.
- rspN_ready while rspN_valid=0 is ignored.
- Arbitration never starves: with both requesters continuously valid, grants alternate 0,1,0,1.
- No arithmetic is performed here. Operands pass unmodified; result width is XLEN.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: req0 always wins when both are valid (fixed priority). last_grant is still maintained but ignored.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Decomposition:
- Shared package alu_pkg:
  - XLEN.
  - funct3 constants: ADD/SUB 3'b000, SLL 3'b001, SLT 3'b010, SLTU 3'b011.
  - FUNCT7_SUB 7'b0100000.
  - FSM state encoding (IDLE/EXEC/RESP).
- One natural sub-module: rr_arb2, the two-input round-robin/fixed-priority picker. Inputs: two valids and last_grant. Output: one-hot winner.
- Everything else lives in alu_req_arbiter.

Test Plan:
- Reset: assert RST mid-EXEC with req0 in flight → same cycle gnt=0, busy=0, rsp0_valid=0, alu_op1=0. After release, no rsp0_valid ever appears for the dropped op.
- Single SUB: req0 op1=5 op2=3 funct3=000 funct7=0100000 imm=0 → req0_ready for 1 cycle. Two cycles after the accept edge, rsp0_valid=1 with rsp0_res=2. rsp1_valid stays 0.
- Simultaneous requests after reset:
  - req0 is ADD 1+2; req1 is SLTU op1=1 op2=all-ones.
  - Expect req0 granted first with rsp0_res=3, then req1 granted with rsp1_res=1.
  - gnt sequence 01 then 10.
- Backpressure: hold rsp0_ready=0 for 5 cycles with req1_valid=1 → rsp0_valid and rsp0_res stable, req1_ready=0 throughout. req1 is accepted only in the IDLE cycle after the rsp0 handshake.
- Fairness: both requesters issue 4 back-to-back ops → grant order 0,1,0,1,0,1,0,1. With ALU_ARB_FIXED_PRIO_EN: 0,0,0,0 then 1,1,1,1.
- Function passthrough:
  - SLT op1=-1 op2=1 → 1.
  - imm=1 funct7=0100000 funct3=000 op1=10 op2=3 → 13, since imm forces ADD.
  - SLL op1=1 op2=63 → 0x8000000000000000.
